// File: rtl/rvm_adder_result_stage_pkg.sv
// Shared compare codes, skid-buffer state encodings and the sign/difference
// flag derivation used by the adder result stage.
package rvm_adder_result_stage_pkg;

  localparam logic [3:0] RVM_CMP_PASS = 4'd0;
  localparam logic [3:0] RVM_CMP_SLT  = 4'd1;
  localparam logic [3:0] RVM_CMP_SLTU = 4'd2;
  localparam logic [3:0] RVM_CMP_BEQ  = 4'd3;
  localparam logic [3:0] RVM_CMP_BNE  = 4'd4;
  localparam logic [3:0] RVM_CMP_BLT  = 4'd5;
  localparam logic [3:0] RVM_CMP_BGE  = 4'd6;
  localparam logic [3:0] RVM_CMP_BLTU = 4'd7;
  localparam logic [3:0] RVM_CMP_BGEU = 4'd8;

  localparam logic [1:0] RVM_RSTG_EMPTY = 2'd0;
  localparam logic [1:0] RVM_RSTG_ONE   = 2'd1;
  localparam logic [1:0] RVM_RSTG_FULL  = 2'd2;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  // Borrow is inferred from operand signs; when signs match, the difference
  // cannot overflow and its MSB is the answer for both orderings.
  function automatic cmp_flags_t derive_flags(input logic [31:0] d,
                                              input logic [31:0] lhs,
                                              input logic [31:0] rhs);
    cmp_flags_t f;
    logic s;
    s     = lhs[31] ^ rhs[31];
    f.eq  = (d == 32'd0);
    f.ltu = s ? rhs[31] : d[31];
    f.lt  = s ? lhs[31] : d[31];
    return f;
  endfunction

endpackage

// File: rtl/rvm_adder_result_stage_if.sv
// Adder-side capture bus and writeback/branch-side result bus of the stage.
// master = surrounding core (adder + consumer), slave = the result stage.
interface rvm_adder_result_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [32:0]      in_result;
  logic [31:0]      in_lhs;
  logic [31:0]      in_rhs;
  logic [3:0]       in_cmp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_taken;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_result, in_lhs, in_rhs, in_cmp, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_taken, out_tag
  );

  modport slave (
    input  in_valid, in_result, in_lhs, in_rhs, in_cmp, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_taken, out_tag
  );
endinterface

// File: rtl/rvm_cmp_derive.sv
// Maps an adder result plus operands onto the stored data/taken pair for a compare code.
// Purely combinational, no latency; no flow control of its own.
module rvm_cmp_derive
  import rvm_adder_result_stage_pkg::*;
(
  input  logic [32:0] in_result,
  input  logic [31:0] in_lhs,
  input  logic [31:0] in_rhs,
  input  logic [3:0]  in_cmp,
  output logic [31:0] data,
  output logic        taken
);
  logic [31:0] d;
  logic        unused_carry;
  cmp_flags_t  flags;

  // Adder carry-out is deliberately ignored; flags come from d and operand signs.
  assign d            = in_result[31:0];
  assign unused_carry = in_result[32];
  assign flags        = derive_flags(d, in_lhs, in_rhs);

  always_comb begin
    data  = 32'd0;
    taken = 1'b0;
    case (in_cmp)
      RVM_CMP_SLT:  data  = {31'd0, flags.lt};
      RVM_CMP_SLTU: data  = {31'd0, flags.ltu};
      RVM_CMP_BEQ:  taken = flags.eq;
      RVM_CMP_BNE:  taken = ~flags.eq;
      RVM_CMP_BLT:  taken = flags.lt;
      RVM_CMP_BGE:  taken = ~flags.lt;
      RVM_CMP_BLTU: taken = flags.ltu;
      RVM_CMP_BGEU: taken = ~flags.ltu;
      default:      data  = d;
    endcase
  end
endmodule

// File: rtl/rvm_adder_result_stage.sv
// Registered 2-entry skid stage after the adder; capture-to-output latency 1 cycle.
// in_ready comes from a flop (low only when both entries are held), so no comb path from out_ready.
module rvm_adder_result_stage
  import rvm_adder_result_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic                   clk,
  input logic                   reset,
  rvm_adder_result_stage_if.slave bus
);
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             rdy_q;
  logic [31:0]      head_data;
  logic             head_taken;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      skid_data;
  logic             skid_taken;
  logic [TAG_W-1:0] skid_tag;
  logic [31:0]      new_data;
  logic             new_taken;
  logic             in_xfer;
  logic             out_xfer;

  rvm_cmp_derive u_derive (
    .in_result (bus.in_result),
    .in_lhs    (bus.in_lhs),
    .in_rhs    (bus.in_rhs),
    .in_cmp    (bus.in_cmp),
    .data      (new_data),
    .taken     (new_taken)
  );

  assign in_xfer  = bus.in_valid && rdy_q;
  assign out_xfer = (state != RVM_RSTG_EMPTY) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      RVM_RSTG_EMPTY: if (in_xfer) state_nxt = RVM_RSTG_ONE;
      RVM_RSTG_ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = RVM_RSTG_FULL;
        else if (!in_xfer && out_xfer) state_nxt = RVM_RSTG_EMPTY;
      end
      RVM_RSTG_FULL:  if (out_xfer) state_nxt = RVM_RSTG_ONE;
      default:        state_nxt = RVM_RSTG_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RVM_RSTG_EMPTY;
      rdy_q      <= 1'b0;
      head_data  <= 32'd0;
      head_taken <= 1'b0;
      head_tag   <= '0;
      skid_data  <= 32'd0;
      skid_taken <= 1'b0;
      skid_tag   <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != RVM_RSTG_FULL);
      case (state)
        RVM_RSTG_EMPTY: begin
          if (in_xfer) begin
            head_data  <= new_data;
            head_taken <= new_taken;
            head_tag   <= bus.in_tag;
          end
        end
        RVM_RSTG_ONE: begin
          // Head leaving while a new entry arrives: new entry goes straight to head.
          if (in_xfer && out_xfer) begin
            head_data  <= new_data;
            head_taken <= new_taken;
            head_tag   <= bus.in_tag;
          end else if (in_xfer) begin
            skid_data  <= new_data;
            skid_taken <= new_taken;
            skid_tag   <= bus.in_tag;
          end
        end
        RVM_RSTG_FULL: begin
          if (out_xfer) begin
            head_data  <= skid_data;
            head_taken <= skid_taken;
            head_tag   <= skid_tag;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state != RVM_RSTG_EMPTY);
  assign bus.out_data  = head_data;
  assign bus.out_taken = head_taken;
  assign bus.out_tag   = head_tag;
endmodule

// File: tb/tb_rvm_adder_result_stage.sv
// Directed and random stimulus for the adder result stage against a queue-based reference model.
module tb_rvm_adder_result_stage;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0]      data;
    logic             taken;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  rvm_adder_result_stage_if #(.TAG_W(TAG_W)) bus ();

  rvm_adder_result_stage #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: compare codes act on the true relation of the operands
  // (the adder is assumed to have produced lhs - rhs for them).
  function automatic exp_t model(input logic [3:0] cmp, input logic [32:0] res,
                                 input logic [31:0] lhs, input logic [31:0] rhs,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    logic eq, lt, ltu;
    eq  = (lhs == rhs);
    lt  = ($signed(lhs) < $signed(rhs));
    ltu = (lhs < rhs);
    e.data  = 32'd0;
    e.taken = 1'b0;
    e.tag   = tag;
    case (cmp)
      4'd1:    e.data  = {31'd0, lt};
      4'd2:    e.data  = {31'd0, ltu};
      4'd3:    e.taken = eq;
      4'd4:    e.taken = !eq;
      4'd5:    e.taken = lt;
      4'd6:    e.taken = !lt;
      4'd7:    e.taken = ltu;
      4'd8:    e.taken = !ltu;
      default: e.data  = res[31:0];
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] cmp, input logic [31:0] lhs,
                       input logic [31:0] rhs, input logic [32:0] res,
                       input logic [TAG_W-1:0] tag);
    bus.in_valid  = vld;
    bus.in_cmp    = cmp;
    bus.in_lhs    = lhs;
    bus.in_rhs    = rhs;
    bus.in_result = res;
    bus.in_tag    = tag;
  endtask

  task automatic drive_rand(input logic vld, input logic [TAG_W-1:0] tag);
    logic [3:0]  cmp;
    logic [31:0] lhs, rhs, r;
    logic        c;
    cmp = 4'($urandom_range(0, 15));
    lhs = $urandom;
    case ($urandom_range(0, 3))
      0:       rhs = lhs;
      1:       rhs = lhs ^ 32'h8000_0000;
      default: rhs = $urandom;
    endcase
    r = (cmp >= 4'd1 && cmp <= 4'd8) ? lhs - rhs : lhs + rhs;
    c = 1'($urandom_range(0, 1));
    drive(vld, cmp, lhs, rhs, {c, r}, tag);
  endtask

  // Observe handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic cycle();
    exp_t e;
    #4;
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_expected_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_taken", 32'(bus.out_taken), 32'(e.taken));
        chk("sb_tag", 32'(bus.out_tag), 32'(e.tag));
      end
    end
    if (bus.in_valid && bus.in_ready)
      sb.push_back(model(bus.in_cmp, bus.in_result, bus.in_lhs, bus.in_rhs, bus.in_tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 4'd0, 32'd0, 32'd0, 33'd0, '0);
    bus.out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_taken", 32'(bus.out_taken), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // PASS latency, wrapped add
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 33'h0_0000_0000, 5'd7);
    cycle();
    bus.in_valid = 1'b0;
    chk("pass_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pass_out_data", bus.out_data, 32'd0);
    chk("pass_out_taken", 32'(bus.out_taken), 32'd0);
    chk("pass_out_tag", 32'(bus.out_tag), 32'd7);
    bus.out_ready = 1'b1;
    cycle();
    chk("pass_drained", 32'(bus.out_valid), 32'd0);

    // Signed vs unsigned
    drive(1'b1, 4'd1, 32'h8000_0000, 32'd1, 33'h0_7FFF_FFFF, 5'd1);
    cycle();
    chk("slt_data", bus.out_data, 32'd1);
    drive(1'b1, 4'd2, 32'h8000_0000, 32'd1, 33'h0_7FFF_FFFF, 5'd2);
    cycle();
    chk("sltu_data", bus.out_data, 32'd0);
    drive(1'b1, 4'd8, 32'h8000_0000, 32'd1, 33'h0_7FFF_FFFF, 5'd3);
    cycle();
    chk("bgeu_taken", 32'(bus.out_taken), 32'd1);
    chk("bgeu_data", bus.out_data, 32'd0);

    // Branch equality
    drive(1'b1, 4'd3, 32'h1234, 32'h1234, 33'd0, 5'd4);
    cycle();
    chk("beq_taken", 32'(bus.out_taken), 32'd1);
    drive(1'b1, 4'd4, 32'h1234, 32'h1234, 33'd0, 5'd5);
    cycle();
    chk("bne_taken", 32'(bus.out_taken), 32'd0);
    drive(1'b1, 4'd5, 32'h1234, 32'h1234, 33'd0, 5'd6);
    cycle();
    chk("blt_taken", 32'(bus.out_taken), 32'd0);
    drive(1'b1, 4'd6, 32'h1234, 32'h1234, 33'd0, 5'd7);
    cycle();
    chk("bge_taken", 32'(bus.out_taken), 32'd1);
    bus.in_valid = 1'b0;
    cycle();
    chk("branch_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure and ordering
    bus.out_ready = 1'b0;
    drive_rand(1'b1, 5'd1);
    cycle();
    drive_rand(1'b1, 5'd2);
    cycle();
    drive_rand(1'b1, 5'd3);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_tag1", 32'(bus.out_tag), 32'd1);
    cycle();
    chk("bp_hold_tag1", 32'(bus.out_tag), 32'd1);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_head_tag2", 32'(bus.out_tag), 32'd2);
    chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
    cycle();
    chk("bp_head_tag3", 32'(bus.out_tag), 32'd3);
    bus.in_valid = 1'b0;
    cycle();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Steady simultaneous stream
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1, 5'(10 + i));
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      cycle();
      chk("stream_tag", 32'(bus.out_tag), 32'(10 + i));
    end
    bus.in_valid = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 5'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream while full
    bus.out_ready = 1'b0;
    drive_rand(1'b1, 5'd20);
    cycle();
    drive_rand(1'b1, 5'd21);
    cycle();
    drive_rand(1'b1, 5'd22);
    chk("mrst_full", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mrst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("mrst_out_data", bus.out_data, 32'd0);
    bus.in_valid = 1'b0;
    sb.delete();
    cycle();
    reset = 1'b0;
    cycle();
    chk("mrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
